uart_rx_cfg: RTL and testbench

Parametrised UART receiver that supersedes the fixed 8N1 receiver. It adds a configurable payload width, optional even/odd parity, and 1 or 2 stop bits. It also adds an input synchroniser, 3-sample majority voting at mid-bit, and per-frame parity, framing and break status. It sits between the uart_rxd pad and the byte-consumer logic; uart_tx pairs with it on the transmit side.

---
 rtl/uart_rx_cfg.sv | 172 +++++++++++++++++
 tb/tb_uart_rx_cfg.sv | 451 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: parametrised UART receiver. Runs the pad through a two-flop
// synchroniser and takes a 3-sample majority vote at mid-bit. Payload width,
// parity and stop-bit count are set by parameters. Each frame reports its
// parity, framing and break status alongside the received payload.
module uart_rx_cfg #(
    parameter int unsigned BIT_RATE     = 9600,
    parameter int unsigned CLK_HZ       = 100000000,
    parameter int unsigned PAYLOAD_BITS = 8,
    parameter int unsigned PARITY_EN    = 0,
    parameter int unsigned PARITY_ODD   = 0,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    uart_rxd,
    input  logic                    recv_en,
    output logic [PAYLOAD_BITS-1:0] recv_data,
    output logic                    recv_valid,
    output logic                    parity_err,
    output logic                    frame_err,
    output logic                    break_det,
    output logic                    busy
);

    localparam int unsigned CPB = CLK_HZ / BIT_RATE;
    localparam int unsigned MID = CPB / 2;
    localparam int unsigned CW  = $clog2(CPB + 1);

    localparam logic [CW-1:0] CYC_LAST  = CW'(CPB - 1);
    localparam logic [CW-1:0] CYC_DEC   = CW'(MID + 1);
    localparam logic [3:0]    DATA_LAST = 4'(PAYLOAD_BITS - 1);
    localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);
    localparam logic          PAR_ON    = (PARITY_EN != 0);
    localparam logic          ODD_BIT   = (PARITY_ODD != 0);

    generate
        if (CPB < 4 || PAYLOAD_BITS < 5 || PAYLOAD_BITS > 9 || PARITY_EN > 1 ||
            PARITY_ODD > 1 || STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_cfg
            $error("uart_rx_cfg: illegal parameter combination");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BRKWAIT
    } state_t;

    state_t                  state, state_nx;
    logic                    rx_meta, rxs, rx_d1, rx_d2;
    logic [CW-1:0]           cyc;
    logic [3:0]              bit_cnt;
    logic [PAYLOAD_BITS-1:0] shreg;
    logic                    par_acc, zero_acc, stop_err;
    logic                    vote, decide, bit_end, done, brk_now;

    // Two-flop synchroniser plus two history taps for the mid-bit vote.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
            rx_d1   <= 1'b1;
            rx_d2   <= 1'b1;
        end else begin
            rx_meta <= uart_rxd;
            rxs     <= rx_meta;
            rx_d1   <= rxs;
            rx_d2   <= rx_d1;
        end
    end

    // At cyc=MID+1 the taps hold the samples from MID-1, MID and MID+1.
    assign vote    = (rx_d2 & rx_d1) | (rx_d2 & rxs) | (rx_d1 & rxs);
    assign decide  = (cyc == CYC_DEC);
    assign bit_end = (cyc == CYC_LAST);
    // Break needs the first stop vote low too. It is still pending only when
    // bit_cnt is 0.
    assign brk_now = zero_acc & ((bit_cnt != 4'd0) | ~vote);
    assign busy    = (state != S_IDLE);

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= S_IDLE;
        else         state <= state_nx;
    end

    // Next-state logic and frame-completion strobe.
    always_comb begin
        state_nx = state;
        done     = 1'b0;
        case (state)
            S_IDLE:    if (!rxs && recv_en) state_nx = S_START;
            S_START: begin
                if (decide && vote) state_nx = S_IDLE;
                else if (bit_end)   state_nx = S_DATA;
            end
            S_DATA:    if (bit_end && bit_cnt == DATA_LAST)
                           state_nx = PAR_ON ? S_PARITY : S_STOP;
            S_PARITY:  if (bit_end) state_nx = S_STOP;
            S_STOP: begin
                // Leave at the final stop decision, half a bit early, to resync.
                if (decide && bit_cnt == STOP_LAST) begin
                    done     = 1'b1;
                    state_nx = (!vote && brk_now) ? S_BRKWAIT : S_IDLE;
                end
            end
            S_BRKWAIT: if (rxs) state_nx = S_IDLE;
            default:   state_nx = S_IDLE;
        endcase
    end

    // Bit timing, bit counting and per-frame accumulators.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cyc      <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            par_acc  <= 1'b0;
            zero_acc <= 1'b1;
            stop_err <= 1'b0;
        end else begin
            if (state == S_IDLE || state == S_BRKWAIT || state_nx == S_IDLE ||
                state_nx == S_BRKWAIT || bit_end)
                cyc <= '0;
            else
                cyc <= cyc + CW'(1);

            if (state_nx != state) bit_cnt <= '0;
            else if (bit_end)      bit_cnt <= bit_cnt + 4'd1;

            if (state == S_IDLE) begin
                shreg    <= '0;
                par_acc  <= 1'b0;
                zero_acc <= 1'b1;
                stop_err <= 1'b0;
            end else if (decide) begin
                case (state)
                    S_DATA: begin
                        shreg    <= {vote, shreg[PAYLOAD_BITS-1:1]};
                        par_acc  <= par_acc ^ vote;
                        zero_acc <= zero_acc & ~vote;
                    end
                    S_PARITY: begin
                        par_acc  <= par_acc ^ vote;
                        zero_acc <= zero_acc & ~vote;
                    end
                    S_STOP: begin
                        stop_err <= stop_err | ~vote;
                        if (bit_cnt == 4'd0) zero_acc <= zero_acc & ~vote;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Completion outputs. Flags are live only in the recv_valid cycle.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            recv_data  <= '0;
            recv_valid <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            break_det  <= 1'b0;
        end else begin
            recv_valid <= done;
            parity_err <= done & PAR_ON & (par_acc ^ ODD_BIT);
            frame_err  <= done & (stop_err | ~vote);
            break_det  <= done & brk_now;
            if (done) recv_data <= shreg;
        end
    end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// tb_uart_rx_cfg: self-checking bench for uart_rx_cfg. Two instances are
// used: 8N1 and 7E2, both at 10 clocks per bit. Expected results come from
// a frame-level model that evaluates the bit sequence put on the line.
module tb_uart_rx_cfg;

    localparam int unsigned CPB = 10;
    localparam int unsigned MID = CPB / 2;
    // Line edge to recv_valid: final stop decision point, synchroniser, output register.
    localparam int unsigned LAT = 9 * CPB + MID + 1 + 2 + 1;

    typedef struct packed {
        logic [8:0] data;
        logic       perr;
        logic       ferr;
        logic       brk;
    } res_t;

    logic       clk = 1'b0;
    logic       resetn;
    logic       rxd_a, en_a, rxd_b, en_b;
    logic [7:0] data_a;
    logic [6:0] data_b;
    logic       valid_a, perr_a, ferr_a, brk_a, busy_a;
    logic       valid_b, perr_b, ferr_b, brk_b, busy_b;

    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned cyc_cnt = 0;
    int unsigned flag_leak = 0;
    res_t        q_a[$], q_b[$], e_a[$], e_b[$];
    int unsigned t_a[$];

    uart_rx_cfg #(.BIT_RATE(100000), .CLK_HZ(1000000), .PAYLOAD_BITS(8),
                  .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_dut_a (
        .clk(clk), .resetn(resetn), .uart_rxd(rxd_a), .recv_en(en_a),
        .recv_data(data_a), .recv_valid(valid_a), .parity_err(perr_a),
        .frame_err(ferr_a), .break_det(brk_a), .busy(busy_a));

    uart_rx_cfg #(.BIT_RATE(100000), .CLK_HZ(1000000), .PAYLOAD_BITS(7),
                  .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2)) u_dut_b (
        .clk(clk), .resetn(resetn), .uart_rxd(rxd_b), .recv_en(en_b),
        .recv_data(data_b), .recv_valid(valid_b), .parity_err(perr_b),
        .frame_err(ferr_b), .break_det(brk_b), .busy(busy_b));

    always #5 clk = ~clk;

    // Free-running cycle counter for latency measurement.
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // Collect completed frames and watch for flags outside recv_valid.
    always @(negedge clk) begin
        if (valid_a) begin
            q_a.push_back(res_t'({1'b0, data_a, perr_a, ferr_a, brk_a}));
            t_a.push_back(cyc_cnt);
        end else if (perr_a | ferr_a | brk_a) flag_leak++;
        if (valid_b) q_b.push_back(res_t'({2'b0, data_b, perr_b, ferr_b, brk_b}));
        else if (perr_b | ferr_b | brk_b) flag_leak++;
    end

    task automatic set_line(input int unsigned dut, input logic v);
        if (dut == 0) rxd_a = v;
        else          rxd_b = v;
    endtask

    // Builds the line bit sequence (bit 0 = start) for the selected instance.
    task automatic build(input int unsigned dut, input logic [8:0] data, input bit flip,
                         input bit stop_low, output logic [15:0] fr, output int unsigned len);
        int unsigned pw;
        logic        p;
        pw = (dut == 0) ? 8 : 7;
        fr = '1;
        fr[0] = 1'b0;
        p = 1'b0;
        for (int unsigned i = 0; i < pw; i++) begin
            fr[1 + i] = data[i];
            p ^= data[i];
        end
        len = 1 + pw;
        if (dut != 0) begin
            fr[len] = p ^ flip;
            len++;
        end
        fr[len] = ~stop_low;
        len += (dut == 0) ? 1 : 2;
    endtask

    // Frame-level reference: derives the expected result from the line bits.
    function automatic res_t model(input int unsigned dut, input logic [15:0] fr);
        res_t        r;
        int unsigned pw, ns, idx;
        logic        x;
        bit          allz;
        r = '0;
        pw = (dut == 0) ? 8 : 7;
        ns = (dut == 0) ? 1 : 2;
        x = 1'b0;
        allz = 1'b1;
        for (int unsigned i = 0; i < pw; i++) begin
            r.data[i] = fr[1 + i];
            x ^= fr[1 + i];
            if (fr[1 + i]) allz = 1'b0;
        end
        idx = 1 + pw;
        if (dut != 0) begin
            x ^= fr[idx];
            if (fr[idx]) allz = 1'b0;
            r.perr = x;
            idx++;
        end
        if (fr[idx]) allz = 1'b0;
        for (int unsigned s = 0; s < ns; s++) if (!fr[idx + s]) r.ferr = 1'b1;
        r.brk = allz;
        return r;
    endfunction

    // Drives a frame CPB cycles per bit. An optional one-cycle inversion
    // lands mid-bit on bit 'spike'. Stops early after max_cyc cycles.
    task automatic drive(input int unsigned dut, input logic [15:0] fr, input int unsigned len,
                         input int spike, input int unsigned max_cyc, output int unsigned t0);
        int unsigned n;
        n = 0;
        t0 = cyc_cnt;
        for (int unsigned i = 0; i < len; i++) begin
            for (int unsigned c = 0; c < CPB; c++) begin
                if (n == max_cyc) return;
                set_line(dut, fr[i] ^ ((int'(i) == spike && c == MID) ? 1'b1 : 1'b0));
                @(negedge clk);
                n++;
            end
        end
        set_line(dut, 1'b1);
    endtask

    task automatic test_reset;
        resetn = 1'b0;
        rxd_a = 1'b1; rxd_b = 1'b1; en_a = 1'b1; en_b = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({data_a, valid_a, perr_a, ferr_a, brk_a, busy_a} !== 13'h0) begin
            errors++;
            $display("FAIL reset_a got=%h exp=0", {data_a, valid_a, perr_a, ferr_a, brk_a, busy_a});
        end
        checks++;
        if ({data_b, valid_b, perr_b, ferr_b, brk_b, busy_b} !== 12'h0) begin
            errors++;
            $display("FAIL reset_b got=%h exp=0", {data_b, valid_b, perr_b, ferr_b, brk_b, busy_b});
        end
        resetn = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_basic;
        logic [15:0] fr;
        int unsigned len, t0, lat;
        res_t        got, exp;
        t_a.delete();
        build(0, 9'h0A5, 1'b0, 1'b0, fr, len);
        exp = model(0, fr);
        drive(0, fr, len, -1, 1000, t0);
        repeat (2 * CPB) @(negedge clk);
        checks++;
        if (q_a.size() != 1) begin
            errors++;
            $display("FAIL basic_count got=%0d exp=1", q_a.size());
        end
        if (q_a.size() != 0) begin
            got = q_a.pop_front();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL basic_frame got=%h exp=%h", got, exp);
            end
            lat = t_a[0] - t0 - 1;
            checks++;
            if (lat + 1 < LAT || lat > LAT + 1) begin
                errors++;
                $display("FAIL basic_latency got=%0d exp=%0d+-1", lat, LAT);
            end
        end
        checks++;
        if (busy_a !== 1'b0) begin
            errors++;
            $display("FAIL basic_busy got=%b exp=0", busy_a);
        end
    endtask

    task automatic test_parity;
        logic [15:0] fr;
        int unsigned len, t0;
        res_t        got, exp;
        for (int unsigned k = 0; k < 2; k++) begin
            build(1, 9'h035, k == 1, 1'b0, fr, len);
            exp = model(1, fr);
            drive(1, fr, len, -1, 1000, t0);
            repeat (2 * CPB) @(negedge clk);
            checks++;
            if (q_b.size() != 1) begin
                errors++;
                $display("FAIL parity_count[%0d] got=%0d exp=1", k, q_b.size());
            end
            if (q_b.size() != 0) begin
                got = q_b.pop_front();
                checks++;
                if (got !== exp || got.perr !== (k == 1)) begin
                    errors++;
                    $display("FAIL parity_frame[%0d] got=%h exp=%h", k, got, exp);
                end
            end
        end
    endtask

    task automatic test_glitch;
        logic [15:0] fr;
        int unsigned len, t0;
        res_t        got, exp;
        rxd_a = 1'b0;
        repeat (3) @(negedge clk);
        rxd_a = 1'b1;
        @(negedge clk);
        checks++;
        if (busy_a !== 1'b1) begin
            errors++;
            $display("FAIL glitch_seen got=%b exp=1", busy_a);
        end
        repeat (3 * CPB) @(negedge clk);
        checks++;
        if (q_a.size() != 0 || busy_a !== 1'b0) begin
            errors++;
            $display("FAIL glitch_reject got=%0d/%b exp=0/0", q_a.size(), busy_a);
        end
        q_a.delete();
        build(0, 9'h0A5, 1'b0, 1'b0, fr, len);
        exp = model(0, fr);
        drive(0, fr, len, 4, 1000, t0);
        repeat (2 * CPB) @(negedge clk);
        checks++;
        if (q_a.size() != 1) begin
            errors++;
            $display("FAIL spike_count got=%0d exp=1", q_a.size());
        end
        if (q_a.size() != 0) begin
            got = q_a.pop_front();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL spike_frame got=%h exp=%h", got, exp);
            end
        end
    endtask

    task automatic test_errors;
        logic [15:0] fr;
        int unsigned len, t0;
        res_t        got, exp;
        build(0, 9'h05A, 1'b0, 1'b1, fr, len);
        exp = model(0, fr);
        drive(0, fr, len, -1, 1000, t0);
        repeat (3 * CPB) @(negedge clk);
        checks++;
        got = (q_a.size() != 0) ? q_a.pop_front() : '1;
        if (got !== exp || got.ferr !== 1'b1 || got.brk !== 1'b0 || q_a.size() != 0) begin
            errors++;
            $display("FAIL frame_err got=%h exp=%h", got, exp);
        end
        exp = model(0, 16'h0000);
        rxd_a = 1'b0;
        repeat (20 * CPB) @(negedge clk);
        checks++;
        if (q_a.size() != 1) begin
            errors++;
            $display("FAIL break_count got=%0d exp=1", q_a.size());
        end
        if (q_a.size() != 0) begin
            got = q_a.pop_front();
            checks++;
            if (got !== exp || got.brk !== 1'b1) begin
                errors++;
                $display("FAIL break_frame got=%h exp=%h", got, exp);
            end
        end
        checks++;
        if (busy_a !== 1'b1) begin
            errors++;
            $display("FAIL break_hold got=%b exp=1", busy_a);
        end
        rxd_a = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        build(0, 9'h03C, 1'b0, 1'b0, fr, len);
        exp = model(0, fr);
        drive(0, fr, len, -1, 1000, t0);
        repeat (2 * CPB) @(negedge clk);
        checks++;
        got = (q_a.size() != 0) ? q_a.pop_front() : '1;
        if (got !== exp || q_a.size() != 0) begin
            errors++;
            $display("FAIL after_break got=%h exp=%h", got, exp);
        end
    endtask

    task automatic test_recv_en;
        logic [15:0] fr;
        int unsigned len, t0;
        res_t        got, exp;
        en_a = 1'b0;
        build(0, 9'h066, 1'b0, 1'b0, fr, len);
        drive(0, fr, len, -1, 1000, t0);
        repeat (2 * CPB) @(negedge clk);
        checks++;
        if (q_a.size() != 0 || busy_a !== 1'b0) begin
            errors++;
            $display("FAIL en_ignore got=%0d/%b exp=0/0", q_a.size(), busy_a);
        end
        q_a.delete();
        en_a = 1'b1;
        build(0, 9'h081, 1'b0, 1'b0, fr, len);
        exp = model(0, fr);
        fork
            drive(0, fr, len, -1, 1000, t0);
            begin
                repeat (3 * CPB) @(negedge clk);
                en_a = 1'b0;
            end
        join
        repeat (2 * CPB) @(negedge clk);
        checks++;
        got = (q_a.size() != 0) ? q_a.pop_front() : '1;
        if (got !== exp || q_a.size() != 0) begin
            errors++;
            $display("FAIL en_drop got=%h exp=%h", got, exp);
        end
        en_a = 1'b1;
    endtask

    task automatic test_reset_mid;
        logic [15:0] fr;
        int unsigned len, t0;
        res_t        got, exp;
        build(0, 9'h000, 1'b0, 1'b0, fr, len);
        drive(0, fr, len, -1, 5 * CPB + MID, t0);
        #2;
        resetn = 1'b0;
        en_a = 1'b0;
        #1;
        checks++;
        if ({data_a, valid_a, perr_a, ferr_a, brk_a, busy_a} !== 13'h0 ||
            {data_b, valid_b, perr_b, ferr_b, brk_b, busy_b} !== 12'h0) begin
            errors++;
            $display("FAIL reset_mid got=%h/%h exp=0/0", {data_a, valid_a, perr_a, ferr_a, brk_a, busy_a},
                     {data_b, valid_b, perr_b, ferr_b, brk_b, busy_b});
        end
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        checks++;
        if (busy_a !== 1'b0 || q_a.size() != 0) begin
            errors++;
            $display("FAIL reset_low_line got=%b/%0d exp=0/0", busy_a, q_a.size());
        end
        rxd_a = 1'b1;
        repeat (CPB) @(negedge clk);
        en_a = 1'b1;
        build(0, 9'h0FF, 1'b0, 1'b0, fr, len);
        exp = model(0, fr);
        drive(0, fr, len, -1, 1000, t0);
        repeat (2 * CPB) @(negedge clk);
        checks++;
        got = (q_a.size() != 0) ? q_a.pop_front() : '1;
        if (got !== exp || q_a.size() != 0) begin
            errors++;
            $display("FAIL reset_recover got=%h exp=%h", got, exp);
        end
    endtask

    // Random frames with random gaps (including back-to-back) on one line.
    task automatic stream(input int unsigned dut, input int unsigned n);
        logic [15:0] fr;
        logic [8:0]  d;
        int unsigned len, t0, gap;
        bit          flip, sl;
        for (int unsigned k = 0; k < n; k++) begin
            d = 9'($urandom_range(0, 511));
            if ($urandom_range(0, 7) == 0) d = '0;
            flip = (dut != 0) && ($urandom_range(0, 3) == 0);
            sl = ($urandom_range(0, 7) == 0);
            build(dut, d, flip, sl, fr, len);
            if (dut == 0) e_a.push_back(model(dut, fr));
            else          e_b.push_back(model(dut, fr));
            drive(dut, fr, len, -1, 1000, t0);
            gap = sl ? $urandom_range(2, 3) : $urandom_range(0, 2);
            repeat (gap * CPB) @(negedge clk);
        end
    endtask

    task automatic test_back_to_back;
        res_t got, exp;
        q_a.delete();
        q_b.delete();
        fork
            stream(0, 25);
            stream(1, 25);
        join
        repeat (3 * CPB) @(negedge clk);
        checks++;
        if (q_a.size() != e_a.size() || q_b.size() != e_b.size()) begin
            errors++;
            $display("FAIL random_count got=%0d/%0d exp=%0d/%0d", q_a.size(), q_b.size(), e_a.size(), e_b.size());
        end
        while (q_a.size() != 0 && e_a.size() != 0) begin
            got = q_a.pop_front();
            exp = e_a.pop_front();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL random_a got=%h exp=%h", got, exp);
            end
        end
        while (q_b.size() != 0 && e_b.size() != 0) begin
            got = q_b.pop_front();
            exp = e_b.pop_front();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL random_b got=%h exp=%h", got, exp);
            end
        end
    endtask

    task automatic test_idle_flags;
        checks++;
        if (flag_leak != 0) begin
            errors++;
            $display("FAIL idle_flags got=%0d exp=0", flag_leak);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_basic();
        test_parity();
        test_glitch();
        test_errors();
        test_recv_en();
        test_reset_mid();
        test_back_to_back();
        test_idle_flags();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
